// File: rtl/alu_issue_pkg.sv
// ----------------------------------------------------------------------------
// alu_issue_pkg
// Shared definitions for the ALU operand-issue slice: the ALU opcode
// encodings, the default datapath and register-index widths, the micro-op
// record, and a small helper used by the forwarding logic.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_issue_pkg;

    // Default widths; the top exposes them as overridable parameters.
    localparam int DW_DEF     = 32;
    localparam int REG_AW_DEF = 3;

    // ALU opcodes, passed straight through to the ALU.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef struct packed {
        logic [2:0]            op;
        logic [REG_AW_DEF-1:0] rd;
        logic [REG_AW_DEF-1:0] rs1;
        logic [REG_AW_DEF-1:0] rs2;
        logic                  imm_sel;
        logic [DW_DEF-1:0]     imm;
    } uop_t;

    // A stage is a forwarding source only when it holds a valid op whose
    // destination matches the source; r0 is never forwarded because it
    // always reads as zero.
    function automatic logic fwd_hit(input logic                  stage_valid,
                                     input logic [REG_AW_DEF-1:0] stage_rd,
                                     input logic [REG_AW_DEF-1:0] rs);
        return stage_valid && (stage_rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// ----------------------------------------------------------------------------
// alu_issue_regfile
// NREGS x DW register file: two combinational read ports, one synchronous
// write port, r0 hard-wired to zero, synchronous active-high clear.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   raddr1_i / rdata1_o  read port 1
//   raddr2_i / rdata2_o  read port 2
//   we_i, waddr_i,       write port (write to r0 is dropped)
//   wdata_i
// ----------------------------------------------------------------------------
module alu_issue_regfile #(
    parameter int DW     = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [DW-1:0]     rdata1_o,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DW-1:0]     rdata2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i
);

    localparam int NREGS = 2 ** REG_AW;

    logic [DW-1:0] regs_q [NREGS];

    // Storage: cleared on reset, otherwise one write per cycle. r0 is never
    // written so it stays at its cleared value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads are combinational and do not see a same-cycle write; the issue
    // stage covers that case by forwarding from W.
    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/alu_operand_issue.sv
// ----------------------------------------------------------------------------
// alu_operand_issue
// Issue stage in front of a combinational DW-bit ALU. Micro-ops are accepted
// over a valid/ready handshake, operands are read from a local register file
// (with forwarding from the E and W stages), a registered E stage drives the
// ALU, and a registered W stage captures the ALU result and presents it
// downstream. The result is written back to the register file when the
// downstream side accepts it.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             micro-op handshake
//   in_op, in_rd, in_rs1, in_rs2, micro-op fields
//   in_imm_sel, in_imm
//   alu_in1, alu_in2, alu_op      to the ALU (from E registers)
//   alu_out                       from the ALU (combinational)
//   res_valid/res_ready           result handshake
//   res_data, res_rd              result value and destination
//   retire_cnt                    retire counter, only when
//                                 ALU_ISSUE_RETIRE_CNT_EN is defined
// ----------------------------------------------------------------------------
module alu_operand_issue
    import alu_issue_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_imm_sel,
    input  logic [DW-1:0]     in_imm,
    output logic [DW-1:0]     alu_in1,
    output logic [DW-1:0]     alu_in2,
    output logic [2:0]        alu_op,
    input  logic [DW-1:0]     alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,
    output logic [REG_AW-1:0] res_rd
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);

    uop_t uop;

    logic              e_valid_q, e_valid_d;
    logic [2:0]        e_op_q,    e_op_d;
    logic [REG_AW-1:0] e_rd_q,    e_rd_d;
    logic [DW-1:0]     e_a_q,     e_a_d;
    logic [DW-1:0]     e_b_q,     e_b_d;

    logic              w_valid_q, w_valid_d;
    logic [DW-1:0]     w_data_q,  w_data_d;
    logic [REG_AW-1:0] w_rd_q,    w_rd_d;

    logic              w_free;
    logic              accept;
    logic              e_to_w;
    logic              retire;

    logic [DW-1:0]     rf_rdata1;
    logic [DW-1:0]     rf_rdata2;
    logic [DW-1:0]     op_a;
    logic [DW-1:0]     op_b;

    // Bundle the incoming fields into a micro-op record.
    always_comb begin
        uop.op      = in_op;
        uop.rd      = in_rd;
        uop.rs1     = in_rs1;
        uop.rs2     = in_rs2;
        uop.imm_sel = in_imm_sel;
        uop.imm     = in_imm;
    end

    // Handshake: W can take a new value if it is empty or draining this
    // cycle; E can accept if it is empty or moving into W this cycle.
    assign w_free   = !w_valid_q || res_ready;
    assign in_ready = !e_valid_q || w_free;
    assign accept   = in_valid && in_ready;
    assign e_to_w   = e_valid_q && w_free;
    assign retire   = w_valid_q && res_ready;

    alu_issue_regfile #(
        .DW     (DW),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk_i    (clk),
        .rst_i    (rst),
        .raddr1_i (uop.rs1),
        .rdata1_o (rf_rdata1),
        .raddr2_i (uop.rs2),
        .rdata2_o (rf_rdata2),
        .we_i     (retire),
        .waddr_i  (w_rd_q),
        .wdata_i  (w_data_q)
    );

    // Operand selection. E is the youngest producer so it wins over W. An
    // accept implies E is either empty or leaving this cycle, so the live
    // ALU output is exactly E's result. W covers a same-cycle retire, since
    // the register file does not bypass its write port.
    always_comb begin
        op_a = rf_rdata1;
        if (fwd_hit(e_valid_q, e_rd_q, uop.rs1)) begin
            op_a = alu_out;
        end else if (fwd_hit(w_valid_q, w_rd_q, uop.rs1)) begin
            op_a = w_data_q;
        end

        op_b = rf_rdata2;
        if (uop.imm_sel) begin
            op_b = uop.imm;
        end else if (fwd_hit(e_valid_q, e_rd_q, uop.rs2)) begin
            op_b = alu_out;
        end else if (fwd_hit(w_valid_q, w_rd_q, uop.rs2)) begin
            op_b = w_data_q;
        end
    end

    // Next state for E and W. E loads on accept and otherwise empties only
    // when its op moves to W; W loads from the ALU on that move and
    // otherwise empties on retire. With neither, both hold so the ALU
    // inputs and result outputs stay stable under backpressure.
    always_comb begin
        e_valid_d = e_valid_q;
        e_op_d    = e_op_q;
        e_rd_d    = e_rd_q;
        e_a_d     = e_a_q;
        e_b_d     = e_b_q;
        w_valid_d = w_valid_q;
        w_data_d  = w_data_q;
        w_rd_d    = w_rd_q;

        if (accept) begin
            e_valid_d = 1'b1;
            e_op_d    = uop.op;
            e_rd_d    = uop.rd;
            e_a_d     = op_a;
            e_b_d     = op_b;
        end else if (e_to_w) begin
            e_valid_d = 1'b0;
        end

        if (e_to_w) begin
            w_valid_d = 1'b1;
            w_data_d  = alu_out;
            w_rd_d    = e_rd_q;
        end else if (retire) begin
            w_valid_d = 1'b0;
        end
    end

    // Pipeline registers. Reset drops anything in flight; because the
    // register file clears on the same edge, nothing is written back.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            e_op_q    <= '0;
            e_rd_q    <= '0;
            e_a_q     <= '0;
            e_b_q     <= '0;
            w_valid_q <= 1'b0;
            w_data_q  <= '0;
            w_rd_q    <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            e_op_q    <= e_op_d;
            e_rd_q    <= e_rd_d;
            e_a_q     <= e_a_d;
            e_b_q     <= e_b_d;
            w_valid_q <= w_valid_d;
            w_data_q  <= w_data_d;
            w_rd_q    <= w_rd_d;
        end
    end

    assign alu_in1   = e_a_q;
    assign alu_in2   = e_b_q;
    assign alu_op    = e_op_q;
    assign res_valid = w_valid_q;
    assign res_data  = w_data_q;
    assign res_rd    = w_rd_q;

`ifdef ALU_ISSUE_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    // Counts retired results; wraps naturally at 2**32.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_issue.sv
// ----------------------------------------------------------------------------
// tb_alu_operand_issue
// Directed bench for alu_operand_issue. A behavioural ALU closes the loop
// from alu_in1/alu_in2/alu_op back to alu_out. Each table row is one clock:
// inputs are applied at the falling edge, in_ready is checked before the
// rising edge, and the E/W outputs are checked at the next falling edge.
// ----------------------------------------------------------------------------
module tb_alu_operand_issue;
    import alu_issue_pkg::*;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_imm_sel;
    logic [31:0] in_imm;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_rd;
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        isel;
        logic [31:0] imm;
        logic        rr;
        logic        expReady;
        logic        chkE;
        logic [31:0] expIn1;
        logic [31:0] expIn2;
        logic [2:0]  expOp;
        logic        expResValid;
        logic        chkW;
        logic [31:0] expData;
        logic [2:0]  expRd;
    } vec_t;

    vec_t vecs[$];

    alu_operand_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd)
`ifdef ALU_ISSUE_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU feeding the DUT's alu_out.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_out = alu_in1 + alu_in2;
            OP_SUB:  alu_out = alu_in1 - alu_in2;
            OP_SHL:  alu_out = alu_in1 << alu_in2;
            OP_SHR:  alu_out = alu_in1 >> alu_in2;
            OP_SRA:  alu_out = $signed(alu_in1) >>> alu_in2;
            OP_AND:  alu_out = alu_in1 & alu_in2;
            OP_OR:   alu_out = alu_in1 | alu_in2;
            default: alu_out = alu_in1 ^ alu_in2;
        endcase
    end

    function automatic vec_t mkVec(input logic v, input logic [2:0] op, rd, rs1, rs2,
                                   input logic isel, input logic [31:0] imm,
                                   input logic rr, input logic expReady,
                                   input logic chkE, input logic [31:0] in1, in2,
                                   input logic [2:0] eop, input logic resV,
                                   input logic chkW, input logic [31:0] data,
                                   input logic [2:0] wrd);
        vec_t t;
        t.v = v;  t.op = op;  t.rd = rd;  t.rs1 = rs1;  t.rs2 = rs2;
        t.isel = isel;  t.imm = imm;  t.rr = rr;  t.expReady = expReady;
        t.chkE = chkE;  t.expIn1 = in1;  t.expIn2 = in2;  t.expOp = eop;
        t.expResValid = resV;  t.chkW = chkW;  t.expData = data;  t.expRd = wrd;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        in_valid   = t.v;
        in_op      = t.op;
        in_rd      = t.rd;
        in_rs1     = t.rs1;
        in_rs2     = t.rs2;
        in_imm_sel = t.isel;
        in_imm     = t.imm;
        res_ready  = t.rr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleCycle(input logic rr);
        applyStimulus(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, rr, Y,
                            N, 32'h0, 32'h0, OP_ADD, N, N, 32'h0, 3'd0));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // v  op  rd rs1 rs2 isel imm  rr rdy | chkE in1 in2 op | resV chkW data rd
        // Immediate load, back-to-back forwarding, regfile read-back.
        vecs.push_back(mkVec(Y, OP_ADD, 3'd1, 3'd0, 3'd0, Y, 32'h5, Y, Y,  Y, 32'h0, 32'h5, OP_ADD,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(Y, OP_ADD, 3'd2, 3'd1, 3'd1, N, 32'h0, Y, Y,  Y, 32'h5, 32'h5, OP_ADD,  Y, Y, 32'h5, 3'd1));
        vecs.push_back(mkVec(Y, OP_SUB, 3'd3, 3'd2, 3'd1, N, 32'h0, Y, Y,  Y, 32'hA, 32'h5, OP_SUB,  Y, Y, 32'hA, 3'd2));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'h5, 3'd3));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(Y, OP_OR,  3'd6, 3'd1, 3'd0, Y, 32'h0, Y, Y,  Y, 32'h5, 32'h0, OP_OR,   N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'h5, 3'd6));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));
        // Backpressure: two accepted, third stalls for four cycles, then drain.
        vecs.push_back(mkVec(Y, OP_ADD, 3'd1, 3'd0, 3'd0, Y, 32'h7, N, Y,  Y, 32'h0, 32'h7, OP_ADD,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(Y, OP_ADD, 3'd2, 3'd0, 3'd0, Y, 32'h8, N, Y,  Y, 32'h0, 32'h8, OP_ADD,  Y, Y, 32'h7, 3'd1));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mkVec(Y, OP_ADD, 3'd3, 3'd0, 3'd0, Y, 32'h9, N, N,  Y, 32'h0, 32'h8, OP_ADD,  Y, Y, 32'h7, 3'd1));
        end
        vecs.push_back(mkVec(Y, OP_ADD, 3'd3, 3'd0, 3'd0, Y, 32'h9, Y, Y,  Y, 32'h0, 32'h9, OP_ADD,  Y, Y, 32'h8, 3'd2));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'h9, 3'd3));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));
        // r0 protection: write to r0 is dropped and r0 is never forwarded.
        vecs.push_back(mkVec(Y, OP_OR,  3'd0, 3'd0, 3'd0, Y, 32'hFFFF, Y, Y,  Y, 32'h0, 32'hFFFF, OP_OR,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'hFFFF, 3'd0));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(Y, OP_ADD, 3'd4, 3'd0, 3'd0, Y, 32'h0, Y, Y,  Y, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'h0, 3'd4));
        vecs.push_back(mkVec(Y, OP_OR,  3'd0, 3'd0, 3'd0, Y, 32'h1234, Y, Y,  Y, 32'h0, 32'h1234, OP_OR,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(Y, OP_ADD, 3'd5, 3'd0, 3'd0, N, 32'h0, Y, Y,  Y, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'h1234, 3'd0));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'h0, 3'd5));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));
        // Shift pass-through, including an amount wider than the datapath.
        vecs.push_back(mkVec(Y, OP_ADD, 3'd1, 3'd0, 3'd0, Y, 32'h80000000, Y, Y,  Y, 32'h0, 32'h80000000, OP_ADD,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(Y, OP_SRA, 3'd5, 3'd1, 3'd0, Y, 32'h4, Y, Y,  Y, 32'h80000000, 32'h4, OP_SRA,  Y, Y, 32'h80000000, 3'd1));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'hF8000000, 3'd5));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(Y, OP_SHL, 3'd6, 3'd5, 3'd0, Y, 32'h21, Y, Y,  Y, 32'hF8000000, 32'h21, OP_SHL,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'h0, 3'd6));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));
        // Two register-file sources (r2=8, r3=9 from the backpressure run).
        vecs.push_back(mkVec(Y, OP_XOR, 3'd7, 3'd2, 3'd3, N, 32'h0, Y, Y,  Y, 32'h8, 32'h9, OP_XOR,  N, N, 32'h0, 3'd0));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  Y, Y, 32'h1, 3'd7));
        vecs.push_back(mkVec(N, OP_ADD, 3'd0, 3'd0, 3'd0, N, 32'h0, Y, Y,  N, 32'h0, 32'h0, OP_ADD,  N, N, 32'h0, 3'd0));

        // Reset held two cycles while a micro-op is offered.
        rst = 1'b1;
        applyStimulus(mkVec(Y, OP_SUB, 3'd1, 3'd2, 3'd3, Y, 32'h77, Y, Y,
                            N, 32'h0, 32'h0, OP_ADD, N, N, 32'h0, 3'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready",  32'(in_ready),  32'h1);
        checkOutput("reset res_valid", 32'(res_valid), 32'h0);
        checkOutput("reset alu_in1",   alu_in1,        32'h0);
        checkOutput("reset alu_in2",   alu_in2,        32'h0);
        checkOutput("reset alu_op",    32'(alu_op),    32'h0);
        checkOutput("reset res_data",  res_data,       32'h0);
        checkOutput("reset res_rd",    32'(res_rd),    32'h0);
`ifdef ALU_ISSUE_RETIRE_CNT_EN
        checkOutput("reset retire_cnt", retire_cnt, 32'h0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("row%0d res_valid", i), 32'(res_valid), 32'(vecs[i].expResValid));
            if (vecs[i].chkE) begin
                checkOutput($sformatf("row%0d alu_in1", i), alu_in1, vecs[i].expIn1);
                checkOutput($sformatf("row%0d alu_in2", i), alu_in2, vecs[i].expIn2);
                checkOutput($sformatf("row%0d alu_op", i), 32'(alu_op), 32'(vecs[i].expOp));
            end
            if (vecs[i].chkW) begin
                checkOutput($sformatf("row%0d res_data", i), res_data, vecs[i].expData);
                checkOutput($sformatf("row%0d res_rd", i), 32'(res_rd), 32'(vecs[i].expRd));
            end
        end

`ifdef ALU_ISSUE_RETIRE_CNT_EN
        checkOutput("retire_cnt total", retire_cnt, 32'd15);
`endif

        // Reset with E and W both full: everything in flight is discarded
        // and r1 must not pick up the W value.
        applyStimulus(mkVec(Y, OP_ADD, 3'd1, 3'd0, 3'd0, Y, 32'h55, N, Y,
                            N, 32'h0, 32'h0, OP_ADD, N, N, 32'h0, 3'd0));
        @(posedge clk);
        @(negedge clk);
        applyStimulus(mkVec(Y, OP_ADD, 3'd2, 3'd0, 3'd0, Y, 32'h66, N, Y,
                            N, 32'h0, 32'h0, OP_ADD, N, N, 32'h0, 3'd0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst pre res_data", res_data, 32'h55);
        checkOutput("midrst pre alu_in2",  alu_in2,  32'h66);
        rst = 1'b1;
        idleCycle(Y);
        rst = 1'b0;
        checkOutput("midrst res_valid", 32'(res_valid), 32'h0);
        checkOutput("midrst in_ready",  32'(in_ready),  32'h1);
        checkOutput("midrst alu_in1",   alu_in1,        32'h0);
        checkOutput("midrst alu_in2",   alu_in2,        32'h0);
        checkOutput("midrst res_data",  res_data,       32'h0);
`ifdef ALU_ISSUE_RETIRE_CNT_EN
        checkOutput("midrst retire_cnt", retire_cnt, 32'h0);
`endif
        applyStimulus(mkVec(Y, OP_OR, 3'd3, 3'd1, 3'd0, Y, 32'h0, Y, Y,
                            N, 32'h0, 32'h0, OP_ADD, N, N, 32'h0, 3'd0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst r1 read", alu_in1, 32'h0);
        idleCycle(Y);
        checkOutput("midrst r3 res_valid", 32'(res_valid), 32'h1);
        checkOutput("midrst r3 res_data",  res_data,       32'h0);
        checkOutput("midrst r3 res_rd",    32'(res_rd),    32'h3);
        idleCycle(Y);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
